// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Register offsets, STATUS/CTRL bit positions and the FSM state type.
package uart_pkg;

    localparam logic [31:0] OFF_TXDATA = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_CTRL   = 32'h8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_PEND    = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_CNT_LSB = 5;
    localparam int ST_PARITY  = 8;

    localparam int CT_ENABLE  = 0;
    localparam int CT_ACK     = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic [2:0] sat_count(input logic [31:0] c);
        return (c > 32'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Transmit FIFO with async active-low reset.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: TXDATA/STATUS/CTRL window, FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE         = 32'hFFFF0040,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd_data,
    output logic        UartAddress,
    output logic        UartInterrupt,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic          r_enable;
    logic          r_pending;
    logic          r_overflow;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic          w_sel_tx;
    logic          w_sel_st;
    logic          w_sel_ct;
    logic          w_wr_tx;
    logic          w_wr_ct;
    logic          w_ack;
    logic          w_bit_end;
    logic          w_pop;
    logic          w_drop;
    logic          w_set_pend;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_rdata;
    logic [31:0]   w_status;
    logic          w_unused_data;

    assign w_sel_tx    = (address == BASE + OFF_TXDATA);
    assign w_sel_st    = (address == BASE + OFF_STATUS);
    assign w_sel_ct    = (address == BASE + OFF_CTRL);
    assign UartAddress = w_sel_tx | w_sel_st | w_sel_ct;

    assign w_wr_tx = MemWrite & w_sel_tx;
    assign w_wr_ct = MemWrite & w_sel_ct;
    assign w_ack   = w_wr_ct & data[CT_ACK];

    assign w_unused_data = ^data[31:8];

    assign w_bit_end = (r_baud == BW'(CLKS_PER_BIT - 1));
    // Pop on registered non-empty only: idle, or at the end of a stop bit.
    assign w_pop = ~w_empty &
                   ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
    assign w_drop     = w_wr_tx & w_full & ~w_pop;
    assign w_set_pend = (r_state == STOP) & w_bit_end & w_empty;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_tx),
        .i_pop   (w_pop),
        .i_wdata (data[7:0]),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_state <= START;
                        r_shift <= w_rdata;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_rdata;
`endif
                    end
                end
                START: begin
                    r_txd <= 1'b0;
                    if (w_bit_end) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_txd <= r_shift[0];
                    if (w_bit_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_txd <= r_par;
                    if (w_bit_end) begin
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    r_txd <= 1'b1;
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_state <= START;
                            r_shift <= w_rdata;
`ifdef UART_TX_PARITY_EN
                            r_par   <= ^w_rdata;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // Set beats ack for both sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable   <= 1'b0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ct) begin
                r_enable <= data[CT_ENABLE];
            end
            r_pending  <= w_set_pend | (r_pending & ~w_ack);
            r_overflow <= w_drop | (r_overflow & ~w_ack);
        end
    end

    always_comb begin
        w_status                      = '0;
        w_status[ST_FULL]             = w_full;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_BUSY]             = (r_state != IDLE);
        w_status[ST_PEND]             = r_pending;
        w_status[ST_OVF]              = r_overflow;
        w_status[ST_CNT_LSB +: 3]     = sat_count(32'(w_count));
`ifdef UART_TX_PARITY_EN
        w_status[ST_PARITY]           = 1'b1;
`endif
    end

    always_comb begin
        rd_data = '0;
        if (MemRead) begin
            unique case (1'b1)
                w_sel_st: rd_data = w_status;
                w_sel_ct: rd_data = {31'b0, r_enable};
                default:  rd_data = '0;
            endcase
        end
    end

    assign UartInterrupt = r_pending & r_enable;
    assign txd           = r_txd;

endmodule
